// File: rtl/cpu_branch_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, flag bit
// positions inside the {Z,N,C,V} flag vector, and the resolve FSM encoding.
// Ports: none (package).
package cpu_branch_pkg;

    // Condition codes carried on Br_Cond
    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LT     = 3'd2;
    localparam logic [2:0] COND_GE     = 3'd3;
    localparam logic [2:0] COND_LTU    = 3'd4;
    localparam logic [2:0] COND_GEU    = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    // Bit positions inside the 4-bit flag vector {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: decides whether a branch is taken from
// the {Z,N,C,V} flags and a 3-bit condition code.
// Ports: flags (in, 4), cond (in, 3), take (out, 1). No latency, no state.
module branch_cond_eval
    import cpu_branch_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ:     take = flags[FLAG_Z];
            COND_NE:     take = ~flags[FLAG_Z];
            COND_LT:     take = flags[FLAG_N] ^ flags[FLAG_V];
            COND_GE:     take = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            COND_LTU:    take = flags[FLAG_C];
            COND_GEU:    take = ~flags[FLAG_C];
            COND_ALWAYS: take = 1'b1;
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolver: holds the ALU flag register, evaluates the branch condition
// (bypassing same-cycle flag writes), issues a one-cycle registered PC redirect
// followed by a FLUSH_CYCLES-long fetch flush, and counts taken/not-taken.
// Ports: clk/rst (sync, active-high); flag inputs Flag_WE/Result_I/Carry_I/Ovf_I;
// branch inputs Br_Valid/Br_Cond/Br_Target; outputs Taken_OUT, Redirect_OUT,
// Target_OUT, Flush_OUT, Flags_OUT, Taken_Cnt, NotTaken_Cnt (all registered).
module branch_resolve_unit
    import cpu_branch_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Flag_WE,
    input  logic [DATA_W-1:0] Result_I,
    input  logic              Carry_I,
    input  logic              Ovf_I,
    input  logic              Br_Valid,
    input  logic [2:0]        Br_Cond,
    input  logic [ADDR_W-1:0] Br_Target,
    output logic              Taken_OUT,
    output logic              Redirect_OUT,
    output logic [ADDR_W-1:0] Target_OUT,
    output logic              Flush_OUT,
    output logic [3:0]        Flags_OUT,
    output logic [CNT_W-1:0]  Taken_Cnt,
    output logic [CNT_W-1:0]  NotTaken_Cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES);

    state_t            state, state_nxt;
    logic [FC_W-1:0]   fcnt, fcnt_nxt;
    logic [3:0]        alu_flags, eval_flags;
    logic              take;
    logic              taken_nxt, redir_nxt, flush_nxt;
    logic [ADDR_W-1:0] target_nxt;
    logic              taken_inc, not_taken_inc;

    always_comb begin
        alu_flags         = 4'b0000;
        alu_flags[FLAG_Z] = (Result_I == '0);
        alu_flags[FLAG_N] = Result_I[DATA_W-1];
        alu_flags[FLAG_C] = Carry_I;
        alu_flags[FLAG_V] = Ovf_I;
    end

    // A branch in the same cycle as a flag write must see the new flags.
    assign eval_flags = Flag_WE ? alu_flags : Flags_OUT;

    branch_cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (Br_Cond),
        .take  (take)
    );

    always_comb begin
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        taken_nxt     = Taken_OUT;
        redir_nxt     = 1'b0;
        target_nxt    = Target_OUT;
        taken_inc     = 1'b0;
        not_taken_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Br_Valid) begin
                    if (take) begin
                        redir_nxt  = 1'b1;
                        target_nxt = Br_Target;
                        taken_nxt  = 1'b1;
                        taken_inc  = 1'b1;
                        state_nxt  = ST_FLUSH;
                        fcnt_nxt   = FC_INIT;
                    end else begin
                        taken_nxt     = 1'b0;
                        not_taken_inc = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // Branches seen here are wrong-path and are dropped.
                if (fcnt <= FC_W'(1)) begin
                    state_nxt = ST_IDLE;
                    fcnt_nxt  = '0;
                end else begin
                    fcnt_nxt = fcnt - FC_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        flush_nxt = (state_nxt == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            fcnt         <= '0;
            Flags_OUT    <= 4'b0000;
            Taken_OUT    <= 1'b0;
            Redirect_OUT <= 1'b0;
            Target_OUT   <= '0;
            Flush_OUT    <= 1'b0;
            Taken_Cnt    <= '0;
            NotTaken_Cnt <= '0;
        end else begin
            state        <= state_nxt;
            fcnt         <= fcnt_nxt;
            Taken_OUT    <= taken_nxt;
            Redirect_OUT <= redir_nxt;
            Target_OUT   <= target_nxt;
            Flush_OUT    <= flush_nxt;
            if (Flag_WE) begin
                Flags_OUT <= alu_flags;
            end
            if (taken_inc && (Taken_Cnt != '1)) begin
                Taken_Cnt <= Taken_Cnt + CNT_W'(1);
            end
            if (not_taken_inc && (NotTaken_Cnt != '1)) begin
                NotTaken_Cnt <= NotTaken_Cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: three instances share stimulus
// (default, FLUSH_CYCLES=3, CNT_W=2); each test resets and checks one instance.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_we;
    logic [15:0] result;
    logic        carry, ovf;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;

    logic        a_taken, a_redir, a_flush;
    logic [15:0] a_target, a_tcnt, a_ncnt;
    logic [3:0]  a_flags;
    logic        b_taken, b_redir, b_flush;
    logic [15:0] b_target, b_tcnt, b_ncnt;
    logic [3:0]  b_flags;
    logic        c_taken, c_redir, c_flush;
    logic [15:0] c_target;
    logic [1:0]  c_tcnt, c_ncnt;
    logic [3:0]  c_flags;

    int checks = 0;
    int passes = 0;
    int exp_t, exp_n;

    always #5 clk = ~clk;

    branch_resolve_unit u_dut_a (
        .clk(clk), .rst(rst), .Flag_WE(flag_we), .Result_I(result), .Carry_I(carry),
        .Ovf_I(ovf), .Br_Valid(br_valid), .Br_Cond(br_cond), .Br_Target(br_target),
        .Taken_OUT(a_taken), .Redirect_OUT(a_redir), .Target_OUT(a_target),
        .Flush_OUT(a_flush), .Flags_OUT(a_flags), .Taken_Cnt(a_tcnt), .NotTaken_Cnt(a_ncnt)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .Flag_WE(flag_we), .Result_I(result), .Carry_I(carry),
        .Ovf_I(ovf), .Br_Valid(br_valid), .Br_Cond(br_cond), .Br_Target(br_target),
        .Taken_OUT(b_taken), .Redirect_OUT(b_redir), .Target_OUT(b_target),
        .Flush_OUT(b_flush), .Flags_OUT(b_flags), .Taken_Cnt(b_tcnt), .NotTaken_Cnt(b_ncnt)
    );

    branch_resolve_unit #(.CNT_W(2)) u_dut_c (
        .clk(clk), .rst(rst), .Flag_WE(flag_we), .Result_I(result), .Carry_I(carry),
        .Ovf_I(ovf), .Br_Valid(br_valid), .Br_Cond(br_cond), .Br_Target(br_target),
        .Taken_OUT(c_taken), .Redirect_OUT(c_redir), .Target_OUT(c_target),
        .Flush_OUT(c_flush), .Flags_OUT(c_flags), .Taken_Cnt(c_tcnt), .NotTaken_Cnt(c_ncnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flag_we = 1'b0; result = 16'h0000; carry = 1'b0; ovf = 1'b0;
        br_valid = 1'b0; br_cond = 3'd0; br_target = 16'h0000;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected take written directly from the condition table, flags = {Z,N,C,V}.
    function automatic logic exp_take(input logic [3:0] f, input logic [2:0] c);
        logic z, n, cy, v;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return n != v;
            3'd3: return n == v;
            3'd4: return cy;
            3'd5: return !cy;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;

        // 1: reset dominates a presented ALWAYS branch
        br_valid = 1'b1; br_cond = 3'd6; br_target = 16'hFFFF;
        tick(); tick();
        check("rst_taken",  32'(a_taken),  32'd0);
        check("rst_redir",  32'(a_redir),  32'd0);
        check("rst_target", 32'(a_target), 32'd0);
        check("rst_flush",  32'(a_flush),  32'd0);
        check("rst_flags",  32'(a_flags),  32'd0);
        check("rst_tcnt",   32'(a_tcnt),   32'd0);
        check("rst_ncnt",   32'(a_ncnt),   32'd0);
        idle_inputs();
        rst = 1'b0;
        tick();

        // 2: Z from zero result, then taken EQ
        flag_we = 1'b1; result = 16'h0000;
        tick();
        flag_we = 1'b0;
        check("t2_flags", 32'(a_flags), 32'h8);
        br_valid = 1'b1; br_cond = 3'd0; br_target = 16'h0040;
        tick();
        idle_inputs();
        check("t2_redir",  32'(a_redir),  32'd1);
        check("t2_target", 32'(a_target), 32'h40);
        check("t2_flush",  32'(a_flush),  32'd1);
        check("t2_taken",  32'(a_taken),  32'd1);
        check("t2_tcnt",   32'(a_tcnt),   32'd1);
        tick();
        check("t2_redir_off", 32'(a_redir),  32'd0);
        check("t2_flush_off", 32'(a_flush),  32'd0);
        check("t2_target_hold", 32'(a_target), 32'h40);

        // 3: bypass -- same-cycle flag write clears Z, EQ not taken
        flag_we = 1'b1; result = 16'h0005; br_valid = 1'b1; br_cond = 3'd0; br_target = 16'h0080;
        tick();
        idle_inputs();
        check("t3_taken", 32'(a_taken), 32'd0);
        check("t3_redir", 32'(a_redir), 32'd0);
        check("t3_ncnt",  32'(a_ncnt),  32'd1);
        check("t3_tcnt",  32'(a_tcnt),  32'd1);
        check("t3_flags", 32'(a_flags), 32'h0);

        // 4: every reachable flag combination (Z and N cannot both be set) x 8 conds
        do_reset();
        exp_t = 0; exp_n = 0;
        for (int f = 0; f < 16; f++) begin
            if (f[3] && f[2]) continue;
            for (int c = 0; c < 8; c++) begin
                flag_we = 1'b1;
                result = f[3] ? 16'h0000 : (f[2] ? 16'h8000 : 16'h0001);
                carry = f[1]; ovf = f[0];
                br_valid = 1'b1; br_cond = 3'(c); br_target = 16'(f * 8 + c);
                tick();
                idle_inputs();
                check($sformatf("t4_flags_f%0d_c%0d", f, c), 32'(a_flags), 32'(f));
                check($sformatf("t4_take_f%0d_c%0d", f, c), 32'(a_taken),
                      32'(exp_take(4'(f), 3'(c))));
                if (exp_take(4'(f), 3'(c))) exp_t++; else exp_n++;
                tick();
            end
        end
        check("t4_tcnt", 32'(a_tcnt), 32'(exp_t));
        check("t4_ncnt", 32'(a_ncnt), 32'(exp_n));

        // 5: FLUSH_CYCLES=3 drops wrong-path branches, accepts on first IDLE cycle
        do_reset();
        br_valid = 1'b1; br_cond = 3'd6; br_target = 16'h0100;
        tick();
        check("t5_redir", 32'(b_redir), 32'd1);
        check("t5_flush", 32'(b_flush), 32'd1);
        check("t5_tcnt",  32'(b_tcnt),  32'd1);
        br_target = 16'h0BAD;
        tick();
        check("t5_f1_redir", 32'(b_redir), 32'd0);
        check("t5_f1_flush", 32'(b_flush), 32'd1);
        flag_we = 1'b1; result = 16'h0000;
        tick();
        flag_we = 1'b0;
        check("t5_f2_flush", 32'(b_flush), 32'd1);
        check("t5_f2_flags", 32'(b_flags), 32'h8);
        tick();
        check("t5_f3_flush", 32'(b_flush), 32'd0);
        check("t5_f3_redir", 32'(b_redir), 32'd0);
        check("t5_f3_tcnt",  32'(b_tcnt),  32'd1);
        check("t5_f3_ncnt",  32'(b_ncnt),  32'd0);
        check("t5_f3_target", 32'(b_target), 32'h100);
        br_target = 16'h0200;
        tick();
        idle_inputs();
        check("t5_acc_redir",  32'(b_redir),  32'd1);
        check("t5_acc_target", 32'(b_target), 32'h200);
        check("t5_acc_tcnt",   32'(b_tcnt),   32'd2);

        // 6: CNT_W=2 saturates at 3; reset mid-flush clears flush
        do_reset();
        for (int i = 0; i < 5; i++) begin
            br_valid = 1'b1; br_cond = 3'd6; br_target = 16'(i + 1);
            tick();
            idle_inputs();
            tick();
            if (i == 2) check("t6_tcnt_3", 32'(c_tcnt), 32'd3);
        end
        check("t6_tcnt_sat", 32'(c_tcnt), 32'd3);
        check("t6_target",   32'(c_target), 32'd5);
        br_valid = 1'b1; br_cond = 3'd6; br_target = 16'h0077;
        tick();
        idle_inputs();
        check("t6_flush_on", 32'(c_flush), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_flush", 32'(c_flush), 32'd0);
        check("t6_rst_redir", 32'(c_redir), 32'd0);
        check("t6_rst_tcnt",  32'(c_tcnt),  32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
